// File: rtl/sign_restore.sv
// sign_restore: rebuilds a 17-bit two's-complement value from a 16-bit
// magnitude and a sign flag. Negative values are formed bit-serially,
// LSB first, by complementing each bit and rippling a +1 carry.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for load; the only state in which a load is accepted
// CONVERT | negating sr one bit per cycle, 16 cycles
// DONE    | out holds the new result, out_valid high for this one cycle
module sign_restore (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        load,
  input  logic [15:0] mag_in,
  input  logic        sign_in,
  output logic [16:0] out,
  output logic        out_valid,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] sr_q, sr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        c_q, c_d;
  logic        s_q, s_d;
  logic [16:0] out_q, out_d;
  logic        err_q, err_d;

  logic        bit_b;
  logic        carry_next;

  // One step of the complement-and-increment chain on the current LSB.
  always_comb begin
    bit_b      = ~sr_q[0] ^ c_q;
    carry_next = ~sr_q[0] & c_q;
  end

  // Next-state, datapath and error-pulse decode.
  // A leftover carry after the 16th bit means the magnitude was zero, so the
  // sign bit is suppressed and negative zero never appears.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    s_d     = s_q;
    out_d   = out_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          sr_d  = mag_in;
          s_d   = sign_in;
          cnt_d = 4'd0;
          c_d   = 1'b1;
          if (sign_in) begin
            state_d = CONVERT;
          end else begin
            state_d = DONE;
            out_d   = {1'b0, mag_in};
          end
        end
      end
      CONVERT: begin
        err_d = load;
        sr_d  = {bit_b, sr_q[15:1]};
        c_d   = carry_next;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = DONE;
          out_d   = {s_q & ~carry_next, bit_b, sr_q[15:1]};
        end
      end
      DONE: begin
        err_d   = load;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      sr_q    <= 16'd0;
      cnt_q   <= 4'd0;
      c_q     <= 1'b0;
      s_q     <= 1'b0;
      out_q   <= 17'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      s_q     <= s_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign out       = out_q;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign err       = err_q;

endmodule
